// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the weighted session arbiter.
package rr_arb_pkg;

  localparam int RR_N_REQ_DEFAULT    = 4;
  localparam int RR_WEIGHT_W_DEFAULT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating first-one finder: lowest set bit of req_masked at or above ptr, wrapping.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module rr_priority_picker #(
  parameter int N_REQ = rr_arb_pkg::RR_N_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0]         req_masked,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W:0] N_WIDE = (IDX_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W:0]     offset;
  logic [IDX_W:0]     sum;

  // Rotating the doubled vector puts ptr at bit 0, so a plain lowest-set-bit search suffices.
  assign doubled = {req_masked, req_masked};
  assign rotated = doubled[ptr +: N_REQ];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = (IDX_W+1)'(k);
      end
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= N_WIDE) begin
      sum = sum - N_WIDE;
    end
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/wrr_session_arbiter.sv
// Weighted round-robin arbiter granting whole sessions; owner keeps grant for up to weight sessions.
// Latency: grant 1 cycle after req seen idle, no bubble between owners. Backpressure: owner holds until finish/abandon.
module wrr_session_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = RR_N_REQ_DEFAULT,
  parameter int WEIGHT_W = RR_WEIGHT_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WEIGHT_W-1:0] weight,
  input  logic                      session_is_finished,
  output logic [N_REQ-1:0]          grant,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    rotate_ptr_q, rotate_ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [WEIGHT_W-1:0] weight_arr [N_REQ];
  logic [WEIGHT_W-1:0] owner_weight;
  logic [WEIGHT_W:0]   eff_weight;
  logic [WEIGHT_W:0]   credit_next;
  logic                owner_req;
  logic                abandon;
  logic                finish;
  logic                session_more;
  logic                release_evt;
  logic [IDX_W-1:0]    ptr_after_owner;

  logic [N_REQ-1:0]    pick_req;
  logic [IDX_W-1:0]    pick_ptr;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [N_REQ-1:0]    pick_onehot;

  for (genvar i = 0; i < N_REQ; i++) begin : g_weight
    assign weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
  end

  // Weight is read live at each finish, so a mid-session change applies at the next comparison.
  assign owner_weight = weight_arr[grant_id_q];
  assign eff_weight   = (owner_weight == '0) ? (WEIGHT_W+1)'(1) : {1'b0, owner_weight};
  assign credit_next  = {1'b0, credit_q} + (WEIGHT_W+1)'(1);
  assign session_more = credit_next < eff_weight;

  assign owner_req   = req[grant_id_q];
  assign abandon     = (state_q == OWN) && !owner_req;
  assign finish      = (state_q == OWN) && owner_req && session_is_finished;
  assign release_evt = abandon || (finish && !session_more);

  assign ptr_after_owner = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  // One picker serves both the idle search and the release-time handover.
  assign pick_req    = (state_q == OWN) ? (req & ~grant_q) : req;
  assign pick_ptr    = (state_q == OWN) ? ptr_after_owner : rotate_ptr_q;
  assign pick_onehot = N_REQ'(1) << pick_idx;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_masked (pick_req),
    .ptr        (pick_ptr),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    rotate_ptr_d = rotate_ptr_q;
    credit_d     = credit_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = OWN;
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          busy_d     = 1'b1;
          credit_d   = '0;
        end
      end
      OWN: begin
        if (release_evt) begin
          rotate_ptr_d = ptr_after_owner;
          credit_d     = '0;
          if (pick_found) begin
            grant_d    = pick_onehot;
            grant_id_d = pick_idx;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            busy_d     = 1'b0;
          end
        end else if (finish) begin
          credit_d = credit_next[WEIGHT_W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      rotate_ptr_q <= '0;
      credit_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      rotate_ptr_q <= rotate_ptr_d;
      credit_q     <= credit_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wrr_session_arbiter.sv
// Bench for wrr_session_arbiter: directed scenarios with literal grants plus a long random run.
module tb_wrr_session_arbiter;

  localparam int N  = 7;
  localparam int WW = 2;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*WW-1:0] weight = '0;
  logic          fin = 1'b0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;

  always #5 clk = ~clk;

  wrr_session_arbiter #(
    .N_REQ    (N),
    .WEIGHT_W (WW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req                 (req),
    .weight              (weight),
    .session_is_finished (fin),
    .grant               (grant),
    .grant_id            (grant_id),
    .busy                (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current owner (-1 = none), sessions used, search start.
  int           m_owner = -1;
  int           m_credit = 0;
  int           m_ptr = 0;
  logic [N-1:0] prev_grant = '0;
  bit           rand_phase = 0;
  int           waitc [N];
  int           max_wait = 0;
  int           sessions = 0;

  function automatic int eff(input logic [N*WW-1:0] w, input int i);
    int v;
    v = int'((w >> (i*WW)) & ((1 << WW) - 1));
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_and_compare
    logic [N-1:0]    r;
    logic            f;
    logic            rs;
    logic [N*WW-1:0] w;
    int              prev_owner;
    bit              rel;
    bit              sess_evt;
    r = req; f = fin; rs = rst; w = weight;
    prev_owner = m_owner;
    rel = 0;
    sess_evt = 0;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_credit = 0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(r, m_ptr);
      m_credit = 0;
    end else begin
      if (!r[m_owner]) rel = 1;
      else if (f) begin
        sess_evt = 1;
        if (m_credit + 1 < eff(w, m_owner)) m_credit++;
        else rel = 1;
      end
      if (rel) begin
        sess_evt = 1;
        m_ptr = (m_owner + 1) % N;
        m_owner = pick(r & ~(N'(1) << m_owner), m_ptr);
        m_credit = 0;
      end
    end
    if (!rs && sess_evt && rand_phase) begin
      sessions++;
      for (int i = 0; i < N; i++) begin
        if (r[i] && i != prev_owner) begin
          waitc[i]++;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!r[i] || i == m_owner) waitc[i] = 0;
    end
    #1;
    chk("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("busy", busy, (m_owner >= 0) ? 1 : 0);
    if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
    chk("onehot0", $onehot0(grant), 1);
    chk("busy_eq_or_grant", busy, |grant);
    if (prev_owner >= 0 && !rs && !rel) chk("grant_stable", grant, prev_grant);
    prev_grant = grant;
  end

  task automatic drive(input logic [N-1:0] r, input logic f);
    req = r;
    fin = f;
    @(posedge clk);
    #2;
  endtask

  task automatic set_w(input int i, input int v);
    weight[i*WW +: WW] = WW'(v);
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_w(i, 1);
    rst = 1'b1;
    drive('0, 1'b0);
    drive('0, 1'b0);
    rst = 1'b0;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);

    // Plain round robin, one finish every 3 cycles.
    drive(7'b0000111, 1'b0);
    chk("rr_first", grant, 7'b0000001);
    drive(7'b0000111, 1'b0);
    drive(7'b0000111, 1'b0);
    chk("rr_hold", grant, 7'b0000001);
    drive(7'b0000111, 1'b1);
    chk("rr_to1", grant, 7'b0000010);
    drive(7'b0000111, 1'b0);
    drive(7'b0000111, 1'b0);
    drive(7'b0000111, 1'b1);
    chk("rr_to2", grant, 7'b0000100);
    drive(7'b0000111, 1'b0);
    drive(7'b0000111, 1'b0);
    drive(7'b0000111, 1'b1);
    chk("rr_to0", grant, 7'b0000001);
    chk("rr_busy", busy, 1);

    // Requester 0 gets three back-to-back sessions.
    set_w(0, 3);
    drive(7'b0000011, 1'b1);
    chk("w3_s1", grant, 7'b0000001);
    drive(7'b0000011, 1'b1);
    chk("w3_s2", grant, 7'b0000001);
    drive(7'b0000011, 1'b1);
    chk("w3_to1", grant, 7'b0000010);
    drive(7'b0000011, 1'b1);
    chk("w3_back0", grant, 7'b0000001);

    // Abandon to idle, finish ignored while idle, then abandon handover 2 -> 3.
    drive(7'b0000000, 1'b0);
    chk("abandon_idle", grant, 0);
    drive(7'b0000000, 1'b1);
    chk("idle_fin_ignored", busy, 0);
    drive(7'b0000010, 1'b0);
    chk("own1", grant, 7'b0000010);
    drive(7'b0000100, 1'b0);
    chk("own2", grant, 7'b0000100);
    drive(7'b0001101, 1'b0);
    chk("own2_hold", grant, 7'b0000100);
    drive(7'b0001001, 1'b0);
    chk("abandon_to3", grant, 7'b0001000);
    chk("abandon_id", grant_id, 3);

    // Finish with nobody else waiting, then re-grant of req3.
    drive(7'b0001000, 1'b1);
    chk("finish_idle_grant", grant, 0);
    chk("finish_idle_busy", busy, 0);
    drive(7'b0001000, 1'b0);
    chk("regrant3", grant, 7'b0001000);

    // Reset mid-session.
    drive(7'b0001111, 1'b0);
    chk("pre_rst", grant, 7'b0001000);
    rst = 1'b1;
    drive(7'b0001111, 1'b0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    drive(7'b0001111, 1'b0);
    chk("post_rst", grant, 7'b0000001);

    // Random traffic against the model.
    rand_phase = 1;
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] r;
      r = req;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(15) == 0) r[i] = ~r[i];
      end
      if ($urandom_range(19) == 0) weight = (N*WW)'($urandom);
      rst = ($urandom_range(399) == 0);
      drive(r, $urandom_range(2) == 0);
    end
    rst = 1'b0;
    rand_phase = 0;
    chk("no_starvation", (max_wait <= N*4) ? 1 : 0, 1);
    chk("sessions_seen", (sessions > 200) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrr_session_arbiter.md
WRR_SESSION_ARBITER -- requirements
Module: wrr_session_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters; legal values are 2 to 16.
REQ-002 The block SHALL have parameter WEIGHT_W, default 3, meaning the width of each per-requester session quota.
REQ-003 The block SHALL have input clk, width 1: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have input rst, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have input req, width N_REQ: per-requester request, bit i for requester i.
REQ-006 The block SHALL have input weight, width N_REQ*WEIGHT_W: session quota per requester, slice i for requester i; a value of 0 is treated as 1.
REQ-007 The block SHALL have input session_is_finished, width 1: the current owner's session ends this cycle.
REQ-008 The block SHALL have output grant, width N_REQ: registered one-hot grant, or all zero.
REQ-009 The block SHALL have output grant_id, width $clog2(N_REQ): registered index of the owner, valid only while busy is high.
REQ-010 The block SHALL have output busy, width 1: registered, high while any grant is held.

Function
REQ-011 The block SHALL implement FSM states IDLE (no owner) and OWN (one owner holds grant).
REQ-012 In IDLE, when req is nonzero, the block SHALL select the first requesting index searching upward from rotate_ptr with wrap N_REQ-1 to 0, then at the next edge set grant, grant_id and busy, enter OWN and clear credit to 0.
REQ-013 Grant latency from req first seen in IDLE SHALL be exactly 1 cycle.
REQ-014 In OWN, grant SHALL remain constant until a release event; changes to other req bits SHALL NOT affect the current grant.
REQ-015 A release event SHALL be session_is_finished=1 in OWN, or owner req=0 in OWN (abandon).
REQ-016 On session_is_finished with owner req still 1 and credit+1 < effective weight, the block SHALL increment credit and keep the same owner (back-to-back session, no bubble).
REQ-017 Otherwise, at a release, the block SHALL set rotate_ptr to (owner+1) mod N_REQ and re-arbitrate in the same cycle over req with the owner bit masked.
REQ-018 If any other requester is pending at release, the new grant SHALL appear at the next edge with no idle cycle, and credit SHALL clear to 0.
REQ-019 If no other requester is pending at release, the block SHALL clear grant and busy at the next edge and enter IDLE.
REQ-020 Abandon SHALL take priority over session_is_finished in the same cycle, and an abandon SHALL never increment credit.
REQ-021 The block SHALL ignore session_is_finished while in IDLE.
REQ-022 The credit counter SHALL be WEIGHT_W bits wide, SHALL compare against the effective weight (0 treated as 1), and SHALL never wrap.
REQ-023 The block SHALL sample weight only at grant and at each session_is_finished; changes mid-session SHALL apply from the next comparison.
REQ-024 grant SHALL be one-hot or zero in every cycle, and busy SHALL equal |grant.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL force grant=0, grant_id=0, busy=0, rotate_ptr=0, credit=0 and state=IDLE, regardless of state.
REQ-026 Reset asserted mid-session SHALL drop grant at that edge; the first grant after rst deasserts SHALL follow REQ-012 with rotate_ptr=0.

Structure
REQ-027 Package rr_arb_pkg SHALL hold the state enum (IDLE, OWN) and the default values for N_REQ and WEIGHT_W.
REQ-028 The block SHALL instantiate one combinational sub-module, rr_priority_picker, taking N_REQ, req_masked and ptr, and returning found and idx.
REQ-029 All outputs SHALL be driven directly from flops, with no combinational path from req to grant.

Verification
REQ-030 With N_REQ=4, all weights 1, req=0111 held and session_is_finished pulsed once every 3 cycles, grant SHALL cycle 0001->0010->0100->0001 with no idle cycle between owners.
REQ-031 With weight0=3, others 1, and req=0011 held, requester 0 SHALL keep grant across 3 sessions, then requester 1 SHALL own it for 1 session, then requester 0 SHALL own it again.
REQ-032 With owner 2 (rotate_ptr=2) and req2 dropped with no finish while req=1001 remains, grant SHALL move to 1000 at the next edge with credit unchanged (abandon).
REQ-033 With the owner finishing and no other request pending, grant SHALL go to 0000 and busy to 0 at the next edge; a new req3 then SHALL be granted 1 cycle later.
REQ-034 Asserting rst for 1 cycle mid-session with req=1111 SHALL give grant=0000 after that edge, then 0001 one cycle after rst falls.
REQ-035 A random bench with N_REQ=7 and WEIGHT_W=2 SHALL check the one-hot invariant, no starvation within N_REQ*4 sessions, and grant stability between release events.
